// File: rtl/trax_pkg.sv
// Trax tile codes, legal-type mask helpers and scanner state encoding.
// Mask bit i stands for tile code i+1. Shared with the tile_check responder.
package trax_pkg;

    localparam logic [2:0] TILE_EMPTY          = 3'd0;
    localparam logic [2:0] TILE_SLASH_UP       = 3'd1;
    localparam logic [2:0] TILE_SLASH_DOWN     = 3'd2;
    localparam logic [2:0] TILE_PLUS_VRT       = 3'd3;
    localparam logic [2:0] TILE_PLUS_HZ        = 3'd4;
    localparam logic [2:0] TILE_BACKSLASH_UP   = 3'd5;
    localparam logic [2:0] TILE_BACKSLASH_DOWN = 3'd6;

    localparam int MASK_W = 6;

    typedef enum logic [3:0] {
        S_IDLE, S_RD_C, S_RD_U, S_RD_D, S_RD_L, S_RD_R,
        S_CAP, S_CHECK, S_WAIT_END, S_WRITE, S_NEXT, S_DONE
    } scan_state_e;

    function automatic logic [MASK_W-1:0] code_to_mask(input logic [2:0] code);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (code == 3'(i + 1)) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Lowest set bit wins; callers only use this on one-hot masks.
    function automatic logic [2:0] mask_to_code(input logic [MASK_W-1:0] mask);
        logic [2:0] code;
        code = TILE_EMPTY;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (mask[i]) code = 3'(i + 1);
        end
        return code;
    endfunction

    function automatic logic [2:0] popcount6(input logic [MASK_W-1:0] mask);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < MASK_W; i++) begin
            n = n + {2'b00, mask[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/trax_nbr_addr.sv
// Board address of a cell and its four neighbours, with on-board flags.
// Addresses of off-board neighbours are meaningless and must be gated by the flag.
module trax_nbr_addr #(
    parameter  int BOARD_W = 8,
    parameter  int BOARD_H = 8,
    localparam int AW      = $clog2(BOARD_W * BOARD_H),
    localparam int RW      = $clog2(BOARD_H),
    localparam int CLW     = $clog2(BOARD_W)
) (
    input  logic [RW-1:0]  row_i,
    input  logic [CLW-1:0] col_i,
    output logic [AW-1:0]  c_addr_o,
    output logic [AW-1:0]  up_addr_o,
    output logic [AW-1:0]  dn_addr_o,
    output logic [AW-1:0]  lf_addr_o,
    output logic [AW-1:0]  rt_addr_o,
    output logic           up_ok_o,
    output logic           dn_ok_o,
    output logic           lf_ok_o,
    output logic           rt_ok_o
);

    int c_int;

    always_comb begin
        c_int     = int'(row_i) * BOARD_W + int'(col_i);
        c_addr_o  = AW'(c_int);
        up_addr_o = AW'(c_int - BOARD_W);
        dn_addr_o = AW'(c_int + BOARD_W);
        lf_addr_o = AW'(c_int - 1);
        rt_addr_o = AW'(c_int + 1);
        up_ok_o   = (row_i != '0);
        dn_ok_o   = (row_i != RW'(BOARD_H - 1));
        lf_ok_o   = (col_i != '0);
        rt_ok_o   = (col_i != CLW'(BOARD_W - 1));
    end

endmodule

// File: rtl/trax_forced_move_scanner.sv
// Repeatedly scans the board, asks tile_check for the legal types of each empty
// cell with a neighbour, and writes back every cell that has exactly one legal type.
module trax_forced_move_scanner
    import trax_pkg::*;
#(
    parameter  int BOARD_W  = 8,
    parameter  int BOARD_H  = 8,
    parameter  int TIMEOUT  = 15,
    parameter  int MAX_PASS = 16,
    localparam int AW       = $clog2(BOARD_W * BOARD_H),
    localparam int CW       = $clog2(BOARD_W * BOARD_H + 1)
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          scan_start_i,
    output logic          scan_busy_o,
    output logic          scan_done_o,
    output logic          scan_error_o,
    output logic [CW-1:0] forced_count_o,
    output logic [AW-1:0] rd_addr_o,
    input  logic [2:0]    rd_data_i,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [2:0]    wr_data_o,
    output logic          chk_start_o,
    output logic [2:0]    chk_up_o,
    output logic [2:0]    chk_down_o,
    output logic [2:0]    chk_left_o,
    output logic [2:0]    chk_right_o,
    input  logic [5:0]    chk_tile_type_i,
    input  logic          chk_end_i
);

    localparam int RW  = $clog2(BOARD_H);
    localparam int CLW = $clog2(BOARD_W);
    localparam int PW  = $clog2(MAX_PASS + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    scan_state_e    state_q, state_d;
    logic [RW-1:0]  row_q, row_d;
    logic [CLW-1:0] col_q, col_d;
    logic [PW-1:0]  pass_q, pass_d;
    logic           dirty_q, dirty_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [2:0]     up_q, up_d, dn_q, dn_d, lf_q, lf_d, rt_q, rt_d;
    logic [2:0]     code_q, code_d;
    logic [CW-1:0]  count_q, count_d;
    logic           err_q, err_d;

    logic [AW-1:0]  c_addr, up_addr, dn_addr, lf_addr, rt_addr;
    logic           up_ok, dn_ok, lf_ok, rt_ok;

    trax_nbr_addr #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H)) u_nbr (
        .row_i     (row_q),
        .col_i     (col_q),
        .c_addr_o  (c_addr),
        .up_addr_o (up_addr),
        .dn_addr_o (dn_addr),
        .lf_addr_o (lf_addr),
        .rt_addr_o (rt_addr),
        .up_ok_o   (up_ok),
        .dn_ok_o   (dn_ok),
        .lf_ok_o   (lf_ok),
        .rt_ok_o   (rt_ok)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            pass_q  <= '0;
            dirty_q <= 1'b0;
            tmo_q   <= '0;
            up_q    <= TILE_EMPTY;
            dn_q    <= TILE_EMPTY;
            lf_q    <= TILE_EMPTY;
            rt_q    <= TILE_EMPTY;
            code_q  <= TILE_EMPTY;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pass_q  <= pass_d;
            dirty_q <= dirty_d;
            tmo_q   <= tmo_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            lf_q    <= lf_d;
            rt_q    <= rt_d;
            code_q  <= code_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Each RD_x state captures the word requested by the previous state.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        pass_d    = pass_q;
        dirty_d   = dirty_q;
        tmo_d     = tmo_q;
        up_d      = up_q;
        dn_d      = dn_q;
        lf_d      = lf_q;
        rt_d      = rt_q;
        code_d    = code_q;
        count_d   = count_q;
        err_d     = err_q;
        rd_addr_o = '0;
        wr_en_o   = 1'b0;
        wr_addr_o = '0;
        wr_data_o = TILE_EMPTY;

        case (state_q)
            S_IDLE: begin
                if (scan_start_i) begin
                    state_d = S_RD_C;
                    row_d   = '0;
                    col_d   = '0;
                    pass_d  = '0;
                    dirty_d = 1'b0;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            S_RD_C: begin
                rd_addr_o = c_addr;
                state_d   = S_RD_U;
            end
            S_RD_U: begin
                if (rd_data_i != TILE_EMPTY) begin
                    state_d = S_NEXT;
                end else begin
                    if (up_ok) rd_addr_o = up_addr;
                    state_d = S_RD_D;
                end
            end
            S_RD_D: begin
                up_d    = up_ok ? rd_data_i : TILE_EMPTY;
                if (dn_ok) rd_addr_o = dn_addr;
                state_d = S_RD_L;
            end
            S_RD_L: begin
                dn_d    = dn_ok ? rd_data_i : TILE_EMPTY;
                if (lf_ok) rd_addr_o = lf_addr;
                state_d = S_RD_R;
            end
            S_RD_R: begin
                lf_d    = lf_ok ? rd_data_i : TILE_EMPTY;
                if (rt_ok) rd_addr_o = rt_addr;
                state_d = S_CAP;
            end
            S_CAP: begin
                rt_d    = rt_ok ? rd_data_i : TILE_EMPTY;
                state_d = ((up_q | dn_q | lf_q | rt_d) == 3'd0) ? S_NEXT : S_CHECK;
            end
            S_CHECK, S_WAIT_END: begin
                // chk_end takes priority over an expiring timeout in the same cycle.
                if (chk_end_i) begin
                    if (popcount6(chk_tile_type_i) == 3'd1) begin
                        code_d  = mask_to_code(chk_tile_type_i);
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_NEXT;
                    end
                end else if (state_q == S_CHECK) begin
                    tmo_d   = TW'(1);
                    state_d = (TIMEOUT <= 1) ? S_NEXT : S_WAIT_END;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_NEXT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_WRITE: begin
                wr_en_o   = 1'b1;
                wr_addr_o = c_addr;
                wr_data_o = code_q;
                dirty_d   = 1'b1;
                if (count_q != CW'(BOARD_W * BOARD_H)) count_d = count_q + CW'(1);
                state_d   = S_NEXT;
            end
            S_NEXT: begin
                state_d = S_RD_C;
                if (col_q != CLW'(BOARD_W - 1)) begin
                    col_d = col_q + CLW'(1);
                end else begin
                    col_d = '0;
                    if (row_q != RW'(BOARD_H - 1)) begin
                        row_d = row_q + RW'(1);
                    end else begin
                        row_d = '0;
                        if (!dirty_q) begin
                            state_d = S_DONE;
                        end else begin
                            dirty_d = 1'b0;
                            pass_d  = pass_q + PW'(1);
                            if (pass_q == PW'(MAX_PASS - 1)) begin
                                err_d   = 1'b1;
                                state_d = S_DONE;
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign scan_busy_o    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign scan_done_o    = (state_q == S_DONE);
    assign scan_error_o   = err_q;
    assign forced_count_o = count_q;
    assign chk_start_o    = (state_q == S_CHECK) || (state_q == S_WAIT_END);
    assign chk_up_o       = up_q;
    assign chk_down_o     = dn_q;
    assign chk_left_o     = lf_q;
    assign chk_right_o    = rt_q;

endmodule

// File: tb/tb_trax_forced_move_scanner.sv
// Randomised bench: board RAM model, tile_check responder and a pass-by-pass
// reference of the forced-move fixed point on an 8x8 board with MAX_PASS=2.
module tb_trax_forced_move_scanner;

    localparam int W = 8;
    localparam int H = 8;
    localparam int N = W * H;
    localparam int TMO = 15;
    localparam int MAXP = 2;

    localparam int M_SINGLE = 1;
    localparam int M_MULTI  = 2;
    localparam int M_NEVER  = 3;
    localparam int M_CHAIN  = 4;
    localparam int M_RAND   = 5;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       scan_start_i;
    logic       scan_busy_o, scan_done_o, scan_error_o;
    logic [6:0] forced_count_o;
    logic [5:0] rd_addr_o;
    logic [2:0] rd_data_i;
    logic       wr_en_o;
    logic [5:0] wr_addr_o;
    logic [2:0] wr_data_o;
    logic       chk_start_o;
    logic [2:0] chk_up_o, chk_down_o, chk_left_o, chk_right_o;
    logic [5:0] chk_tile_type_i;
    logic       chk_end_i;

    always #5 clk_i = ~clk_i;

    trax_forced_move_scanner #(.BOARD_W(W), .BOARD_H(H), .TIMEOUT(TMO), .MAX_PASS(MAXP)) dut (
        .clock_i         (clk_i),
        .reset_i         (rst_i),
        .scan_start_i    (scan_start_i),
        .scan_busy_o     (scan_busy_o),
        .scan_done_o     (scan_done_o),
        .scan_error_o    (scan_error_o),
        .forced_count_o  (forced_count_o),
        .rd_addr_o       (rd_addr_o),
        .rd_data_i       (rd_data_i),
        .wr_en_o         (wr_en_o),
        .wr_addr_o       (wr_addr_o),
        .wr_data_o       (wr_data_o),
        .chk_start_o     (chk_start_o),
        .chk_up_o        (chk_up_o),
        .chk_down_o      (chk_down_o),
        .chk_left_o      (chk_left_o),
        .chk_right_o     (chk_right_o),
        .chk_tile_type_i (chk_tile_type_i),
        .chk_end_i       (chk_end_i)
    );

    int checks = 0;
    int errors = 0;
    int mode = M_MULTI;
    int rand_seed = 0;
    logic [2:0] mem [0:N-1];
    int bm [0:N-1];
    int exp_wr[$], obs_wr[$], exp_q[$], obs_q[$];
    int exp_cnt;
    int exp_err;

    task automatic check(input string tag, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // Board RAM: one-cycle read latency, old data on a same-cycle write.
    always @(posedge clk_i) begin
        rd_data_i <= mem[rd_addr_o];
        if (wr_en_o) mem[wr_addr_o] = wr_data_o;
    end

    function automatic logic [5:0] resp_mask(input int md, input int u, input int d, input int l, input int r);
        int h;
        case (md)
            M_SINGLE: return (l == 4 && u == 0 && d == 0 && r == 0) ? 6'b000001 : 6'b000000;
            M_MULTI:  return 6'b001010;
            M_CHAIN:  return (r != 0 && u == 0 && d == 0 && l == 0) ? 6'b000001 : 6'b000000;
            M_RAND: begin
                h = (u * 7 + d * 13 + l * 29 + r * 53 + rand_seed) % 11;
                if (h < 6) return 6'b000001 << h;
                if (h < 9) return 6'b000000;
                return 6'b100100;
            end
            default: return 6'b000000;
        endcase
    endfunction

    // Fixed point computed directly on an array copy of the board.
    function automatic void run_model();
        int u, d, l, rr, code, idx;
        bit dirty;
        logic [5:0] m;
        exp_wr.delete();
        exp_q.delete();
        exp_cnt = 0;
        exp_err = 0;
        for (int p = 0; p < MAXP; p++) begin
            dirty = 0;
            for (int r = 0; r < H; r++) begin
                for (int c = 0; c < W; c++) begin
                    idx = r * W + c;
                    if (bm[idx] == 0) begin
                        u  = (r > 0)     ? bm[idx - W] : 0;
                        d  = (r < H - 1) ? bm[idx + W] : 0;
                        l  = (c > 0)     ? bm[idx - 1] : 0;
                        rr = (c < W - 1) ? bm[idx + 1] : 0;
                        if (u + d + l + rr != 0) begin
                            exp_q.push_back(u * 512 + d * 64 + l * 8 + rr);
                            m = (mode == M_NEVER) ? 6'b0 : resp_mask(mode, u, d, l, rr);
                            if ($countones(m) == 1) begin
                                code = 0;
                                for (int i = 0; i < 6; i++) if (m[i]) code = i + 1;
                                bm[idx] = code;
                                exp_wr.push_back(idx * 8 + code);
                                if (exp_cnt < N) exp_cnt++;
                                dirty = 1;
                            end
                        end
                    end
                end
            end
            if (!dirty) break;
            if (p == MAXP - 1) exp_err = 1;
        end
    endfunction

    // tile_check responder: answers after a random latency unless in M_NEVER.
    initial begin : responder
        int wait_cnt;
        bit hold;
        wait_cnt = 0;
        hold = 0;
        chk_end_i = 1'b0;
        chk_tile_type_i = 6'b0;
        forever begin
            @(negedge clk_i);
            chk_end_i = 1'b0;
            if (!chk_start_o) begin
                hold = 0;
                wait_cnt = (mode == M_RAND) ? $urandom_range(0, TMO - 1) : $urandom_range(0, 3);
            end else if (!hold) begin
                if (wait_cnt == 0) begin
                    if (mode != M_NEVER) begin
                        chk_end_i = 1'b1;
                        chk_tile_type_i = resp_mask(mode, chk_up_o, chk_down_o, chk_left_o, chk_right_o);
                        hold = 1;
                    end
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // Transaction monitor: writes, queries and chk_start hold length.
    int hi_len = 0;
    logic chk_prev = 1'b0;
    always @(negedge clk_i) begin
        if (rst_i) begin
            hi_len = 0;
        end else begin
            if (wr_en_o) obs_wr.push_back(int'(wr_addr_o) * 8 + int'(wr_data_o));
            if (chk_start_o && !chk_prev)
                obs_q.push_back(int'(chk_up_o) * 512 + int'(chk_down_o) * 64 + int'(chk_left_o) * 8 + int'(chk_right_o));
            if (chk_start_o) begin
                hi_len++;
            end else if (hi_len > 0) begin
                if (mode == M_NEVER) check("chk_start_len", hi_len, TMO);
                else check("chk_start_len_le", int'(hi_len <= TMO), 1);
                hi_len = 0;
            end
        end
        chk_prev = chk_start_o;
    end

    task automatic clear_board();
        for (int i = 0; i < N; i++) mem[i] = 3'd0;
    endtask

    task automatic random_board();
        for (int i = 0; i < N; i++)
            mem[i] = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 6)) : 3'd0;
    endtask

    task automatic run_scan(input string name, input int md, input bit extra_start);
        bit seen;
        int ns;
        mode = md;
        for (int i = 0; i < N; i++) bm[i] = int'(mem[i]);
        run_model();
        obs_wr.delete();
        obs_q.delete();
        @(negedge clk_i);
        scan_start_i = 1'b1;
        @(negedge clk_i);
        scan_start_i = 1'b0;
        check({name, "_busy"}, int'(scan_busy_o), 1);
        check({name, "_addr0"}, int'(rd_addr_o), 0);
        check({name, "_cnt_clr"}, int'(forced_count_o), 0);
        check({name, "_err_clr"}, int'(scan_error_o), 0);
        seen = 0;
        for (int cyc = 0; cyc < 30000 && !seen; cyc++) begin
            @(negedge clk_i);
            scan_start_i = (extra_start && cyc == 40) ? 1'b1 : 1'b0;
            if (scan_done_o) seen = 1;
        end
        scan_start_i = 1'b0;
        check({name, "_done"}, int'(seen), 1);
        check({name, "_busy_at_done"}, int'(scan_busy_o), 0);
        check({name, "_count"}, int'(forced_count_o), exp_cnt);
        check({name, "_error"}, int'(scan_error_o), exp_err);
        check({name, "_n_wr"}, obs_wr.size(), exp_wr.size());
        check({name, "_n_chk"}, obs_q.size(), exp_q.size());
        ns = (obs_wr.size() < exp_wr.size()) ? obs_wr.size() : exp_wr.size();
        for (int i = 0; i < ns; i++) check({name, "_wr"}, obs_wr[i], exp_wr[i]);
        ns = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < ns; i++) check({name, "_nbrs"}, obs_q[i], exp_q[i]);
        @(negedge clk_i);
        check({name, "_done_pulse"}, int'(scan_done_o), 0);
        check({name, "_err_sticky"}, int'(scan_error_o), exp_err);
        $display("scan %s: writes=%0d queries=%0d count=%0d error=%0d", name,
                 obs_wr.size(), obs_q.size(), forced_count_o, scan_error_o);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, int'(scan_busy_o), 0);
        check({tag, "_done"}, int'(scan_done_o), 0);
        check({tag, "_err"}, int'(scan_error_o), 0);
        check({tag, "_cnt"}, int'(forced_count_o), 0);
        check({tag, "_rd_addr"}, int'(rd_addr_o), 0);
        check({tag, "_wr"}, int'({wr_en_o, wr_addr_o, wr_data_o}), 0);
        check({tag, "_chk"}, int'({chk_start_o, chk_up_o, chk_down_o, chk_left_o, chk_right_o}), 0);
    endtask

    initial begin : main
        bit seen;
        rst_i = 1'b1;
        scan_start_i = 1'b0;
        clear_board();
        repeat (3) @(negedge clk_i);
        check_outputs_zero("reset");
        rst_i = 1'b0;
        @(negedge clk_i);

        clear_board();
        run_scan("empty", M_MULTI, 0);

        clear_board();
        mem[3 * W + 3] = 3'd4;
        run_scan("single", M_SINGLE, 0);
        check("single_wr28", (obs_wr.size() > 0) ? obs_wr[0] : -1, 28 * 8 + 1);
        check("single_cnt1", int'(forced_count_o), 1);

        random_board();
        run_scan("multi", M_MULTI, 1);

        clear_board();
        mem[2 * W + 5] = 3'd3;
        mem[6 * W + 1] = 3'd5;
        run_scan("never", M_NEVER, 0);

        clear_board();
        mem[W - 1] = 3'd4;
        run_scan("chain", M_CHAIN, 0);
        check("chain_err", int'(scan_error_o), 1);
        check("chain_cnt2", int'(forced_count_o), 2);

        for (int k = 0; k < 4; k++) begin
            rand_seed = int'($urandom_range(0, 1000));
            random_board();
            run_scan($sformatf("rand%0d", k), M_RAND, 0);
        end

        // Reset in the middle of a pending check.
        clear_board();
        mem[4 * W + 4] = 3'd2;
        mode = M_NEVER;
        @(negedge clk_i);
        scan_start_i = 1'b1;
        @(negedge clk_i);
        scan_start_i = 1'b0;
        seen = 0;
        for (int cyc = 0; cyc < 2000 && !seen; cyc++) begin
            @(negedge clk_i);
            if (chk_start_o) seen = 1;
        end
        check("rst_reached_wait", int'(seen), 1);
        repeat (4) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check_outputs_zero("rst_async");
        @(posedge clk_i);
        #1;
        check_outputs_zero("rst_edge");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        run_scan("after_rst", M_MULTI, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
